blink_arbiter: RTL and testbench

Shares one LED blink resource among `N_REQ` requesters. Grants it round-robin and runs a fixed-length blink sequence for the winner: `BLINKS` on/off pulses with programmable on and off widths. It then reports completion and releases the resource. It sits between client request logic and the LED pin, and replaces the per-client external `i_ena` tick generation and start sequencing.

---
 rtl/blink_arbiter.sv | 147 ++++++++++++++
 tb/tb_blink_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_arbiter.sv
// Round-robin owner of one shared LED blinker: grants a requester and runs BLINKS on/off pulses.
// Optional macro BLINK_ARB_ABORT_EN: dropping the granted request returns to idle without o_done.
module blink_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ON_CYC  = 8,
   parameter int unsigned OFF_CYC = 8,
   parameter int unsigned BLINKS  = 3,
   parameter int unsigned CNT_W   = 8,
   localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N_REQ-1:0] i_req,
   output logic [N_REQ-1:0] o_gnt,
   output logic             o_out,
   output logic             o_busy,
   output logic [3:0]       o_blink_idx,
   output logic             o_done,
   output logic [IDX_W-1:0] o_done_id
);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYC - 1);
   localparam logic [3:0]       IDX_LAST = 4'(BLINKS - 1);
   localparam logic [IDX_W-1:0] REQ_TOP  = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             out_q, out_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] done_id_q, done_id_d;
   logic [IDX_W-1:0] last_q, last_d;

   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand;

   // Scan from last_q+1 upward, wrapping, so the most recent winner has lowest priority.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = last_q;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = (cand == REQ_TOP) ? '0 : cand + IDX_W'(1);
         if (!pick_found && i_req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      gnt_d     = gnt_q;
      out_d     = out_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      last_d    = last_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               state_d = StOn;
               cnt_d   = '0;
               idx_d   = '0;
               gnt_d   = N_REQ'(1) << pick_idx;
               out_d   = 1'b1;
               last_d  = pick_idx;
            end
         end
         StOn: begin
            if (cnt_q == ON_LAST) begin
               state_d = StOff;
               cnt_d   = '0;
               out_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StOff: begin
            if (cnt_q == OFF_LAST) begin
               cnt_d = '0;
               if (idx_q < IDX_LAST) begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StOn;
                  out_d   = 1'b1;
               end else begin
                  state_d   = StIdle;
                  idx_d     = '0;
                  gnt_d     = '0;
                  done_d    = 1'b1;
                  done_id_d = last_q;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef BLINK_ARB_ABORT_EN
      // last_q is left on the aborted index so priority rotates past it.
      if (state_q != StIdle && !(|(i_req & gnt_q))) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
         gnt_d   = '0;
         out_d   = 1'b0;
         done_d  = 1'b0;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         gnt_q     <= '0;
         out_q     <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         last_q    <= REQ_TOP;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         gnt_q     <= gnt_d;
         out_q     <= out_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         last_q    <= last_d;
      end
   end

   assign o_gnt       = gnt_q;
   assign o_busy      = |gnt_q;
   assign o_out       = out_q;
   assign o_blink_idx = idx_q;
   assign o_done      = done_q;
   assign o_done_id   = done_id_q;

endmodule

// File: tb/tb_blink_arbiter.sv
// Bench for blink_arbiter: grant-timeline model checked every cycle plus directed literal checks.
// Follows BLINK_ARB_ABORT_EN the same way the design does.
module tb_blink_arbiter;

   localparam int N   = 4;
   localparam int ON  = 2;
   localparam int OFF = 3;
   localparam int BL  = 3;
   localparam int P   = ON + OFF;
   localparam int L   = BL * P;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] o_gnt;
   logic       o_out, o_busy, o_done;
   logic [3:0] o_blink_idx;
   logic [1:0] o_done_id;

   int checks = 0;
   int failures = 0;

   blink_arbiter #(
      .N_REQ(N), .ON_CYC(ON), .OFF_CYC(OFF), .BLINKS(BL), .CNT_W(8)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_gnt(o_gnt), .o_out(o_out),
      .o_busy(o_busy), .o_blink_idx(o_blink_idx), .o_done(o_done), .o_done_id(o_done_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a grant is an owner plus the cycle count since it started.
   int   m_owner = -1;
   int   m_t = 0;
   int   m_last = N - 1;
   bit   m_done = 0;
   int   m_done_id = 0;
   logic [3:0] req_s;
   logic       rst_s;
   int   gnt_log[$];
   int   done_log[$];
   logic [3:0] prev_gnt = 4'b0000;

   initial begin
      forever begin
         @(posedge clk);
         req_s = req;
         rst_s = rst_n;
         if (!rst_s) begin
            m_owner = -1; m_t = 0; m_last = N - 1; m_done = 0;
         end else begin
            m_done = 0;
            if (m_owner >= 0) begin
               bit abort;
               abort = 0;
`ifdef BLINK_ARB_ABORT_EN
               abort = !req_s[m_owner];
`endif
               if (abort) begin
                  m_owner = -1;
               end else begin
                  m_t++;
                  if (m_t == L) begin
                     m_done = 1; m_done_id = m_owner; m_owner = -1;
                  end
               end
            end else if (req_s != 4'b0000) begin
               for (int k = 1; k <= N; k++) begin
                  int c;
                  c = (m_last + k) % N;
                  if (req_s[c]) begin
                     m_owner = c; m_last = c; m_t = 0;
                     break;
                  end
               end
            end
         end
         #1;
         check("model o_gnt", int'(o_gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
         check("model o_busy", int'(o_busy), (m_owner >= 0) ? 1 : 0);
         check("model o_out", int'(o_out), (m_owner >= 0 && (m_t % P) < ON) ? 1 : 0);
         check("model o_done", int'(o_done), int'(m_done));
         if (m_done) check("model o_done_id", int'(o_done_id), m_done_id);
         if (m_owner >= 0) check("model o_blink_idx", int'(o_blink_idx), m_t / P);
         if (o_done) done_log.push_back(int'(o_done_id));
         if (o_gnt != 4'b0000 && prev_gnt == 4'b0000) gnt_log.push_back(int'(o_gnt));
         prev_gnt = o_gnt;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = 4'b0000;
      nclk(2);
      rst_n = 1'b1;
   endtask

   // Returns at the negedge inside the o_done cycle.
   task automatic wait_done(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("done timeout", 0, 1);
   endtask

   initial begin
      logic [14:0] pat;
      int exp_g[5];
      int exp_d[5];
      int exp_wg[3];
      int exp_wd[3];
      int cnt;

      // Reset values
      nclk(2);
      check("reset o_gnt", int'(o_gnt), 0);
      check("reset o_out", int'(o_out), 0);
      check("reset o_busy", int'(o_busy), 0);
      check("reset o_done", int'(o_done), 0);
      check("reset o_blink_idx", int'(o_blink_idx), 0);

      // Single request: 15 grant cycles, 11000 x3, done on cycle 16
      rst_n = 1'b1;
      req = 4'b0001;
      pat = 15'b110001100011000;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("single o_gnt", int'(o_gnt), 1);
         check("single o_out", int'(o_out), int'(pat[14-k]));
         check("single o_blink_idx", int'(o_blink_idx), k / 5);
      end
      @(negedge clk);
      check("single o_done", int'(o_done), 1);
      check("single o_done_id", int'(o_done_id), 0);
      check("single o_gnt after", int'(o_gnt), 0);
      req = 4'b0000;

      // Round robin from reset with all requesting
      do_reset();
      gnt_log.delete();
      done_log.delete();
      req = 4'b1111;
      for (int i = 0; i < 200 && done_log.size() < 5; i++) @(negedge clk);
      req = 4'b0000;
      exp_g = '{1, 2, 4, 8, 1};
      exp_d = '{0, 1, 2, 3, 0};
      check("rr grant count", gnt_log.size(), 5);
      check("rr done count", done_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < gnt_log.size()) check("rr grant order", gnt_log[i], exp_g[i]);
         if (i < done_log.size()) check("rr done_id order", done_log[i], exp_d[i]);
      end

      // Wrap-around: serve 3, then 1001 -> 0 before 3
      nclk(2);
      gnt_log.delete();
      done_log.delete();
      req = 4'b1000;
      wait_done(40);
      req = 4'b1001;
      wait_done(40);
      wait_done(40);
      req = 4'b0000;
      exp_wg = '{8, 1, 8};
      exp_wd = '{3, 0, 3};
      check("wrap grant count", gnt_log.size(), 3);
      for (int i = 0; i < 3; i++) begin
         if (i < gnt_log.size()) check("wrap grant order", gnt_log[i], exp_wg[i]);
         if (i < done_log.size()) check("wrap done_id order", done_log[i], exp_wd[i]);
      end

      // Reset during the second ON phase
      nclk(2);
      req = 4'b0001;
      nclk(6);
      check("second ON o_out", int'(o_out), 1);
      check("second ON o_blink_idx", int'(o_blink_idx), 1);
      rst_n = 1'b0;
      req = 4'b0000;
      #1;
      check("mid reset o_out", int'(o_out), 0);
      check("mid reset o_gnt", int'(o_gnt), 0);
      check("mid reset o_busy", int'(o_busy), 0);
      check("mid reset o_done", int'(o_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b0100;
      @(negedge clk);
      check("post reset o_gnt", int'(o_gnt), 4);
      check("post reset o_blink_idx", int'(o_blink_idx), 0);
      wait_done(40);
      check("post reset o_done_id", int'(o_done_id), 2);
      req = 4'b0000;

      // Requester 1 drops its request in cycle 4 of its grant, requester 0 pending
      do_reset();
      req = 4'b0001;
      wait_done(40);
      req = 4'b0011;
      nclk(4);
      check("drop pre o_gnt", int'(o_gnt), 2);
      req = 4'b0001;
`ifdef BLINK_ARB_ABORT_EN
      nclk(1);
      check("abort o_gnt", int'(o_gnt), 0);
      check("abort o_out", int'(o_out), 0);
      check("abort o_done", int'(o_done), 0);
      nclk(1);
      check("abort next o_gnt", int'(o_gnt), 1);
      wait_done(40);
      check("abort next o_done_id", int'(o_done_id), 0);
      req = 4'b0000;
`else
      cnt = 4;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_gnt == 4'b0010) cnt++;
         else break;
      end
      check("noabort grant length", cnt, 15);
      check("noabort o_done", int'(o_done), 1);
      check("noabort o_done_id", int'(o_done_id), 1);
      req = 4'b0000;
`endif

      nclk(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
